pwm_capture: RTL and testbench

- Bus-mapped PWM/duty-cycle capture peripheral. It is the receive-side counterpart to the team's PWM analog output peripheral.
- Samples one asynchronous digital input, then measures high time and period between consecutive rising edges in clk cycles.
- Latches each completed measurement into registers that the CPU reads over the standard valid/ready/wstrb/addr/wdata/rdata peripheral bus.
- Sits beside the PWM output block on the same peripheral bus. Used for reading PWM-encoded analog sensors and for loopback of the PWM output.

---
 rtl/pwm_capture.sv | 153 +++++++++++++++
 tb/tb_pwm_capture.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// PWM capture peripheral: synchronizes in_i, measures high time and period between
// rising edges, and exposes the latched results on the valid/ready peripheral bus.
module pwm_capture #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [3:0]  wstrb_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  input  logic        in_i
);
  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    sat_inc = (v == CNT_MAX) ? CNT_MAX : v + CNT_ONE;
  endfunction

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   enable_q, enable_d;
  logic                   armed_q, armed_d;
  logic                   new_q, new_d;
  logic                   ovf_q, ovf_d;
  logic [WIDTH-1:0]       high_q, high_d;
  logic [WIDTH-1:0]       period_q, period_d;
  logic [WIDTH-1:0]       high_cnt_q, high_cnt_d;
  logic [WIDTH-1:0]       period_cnt_q, period_cnt_d;
  logic                   ready_q, ready_d;
  logic [31:0]            rdata_q, rdata_d;
  logic                   s_s, rise_s, accept_s, wr_s;
  logic                   unused_s;

  assign s_s      = sync_q[SYNC_STAGES-1];
  assign rise_s   = s_s & ~prev_q;
  assign ready_o  = ready_q;
  assign rdata_o  = rdata_q;
  assign unused_s = ^{addr_i[31:4], addr_i[1:0], wdata_i[31:2]};

  // Next-state: synchronizer, bus decode, register writes and measurement
  always_comb begin
    sync_d       = {sync_q[SYNC_STAGES-2:0], in_i};
    prev_d       = s_s;
    accept_s     = valid_i & ~ready_q;
    wr_s         = accept_s & (wstrb_i != 4'h0);
    ready_d      = accept_s;
    rdata_d      = rdata_q;
    enable_d     = enable_q;
    armed_d      = armed_q;
    new_d        = new_q;
    ovf_d        = ovf_q;
    high_d       = high_q;
    period_d     = period_q;
    high_cnt_d   = high_cnt_q;
    period_cnt_d = period_cnt_q;

    if (accept_s) begin
      case (addr_i[3:2])
        2'd0:    rdata_d = {31'd0, enable_q};
        2'd1:    rdata_d = {30'd0, ovf_q, new_q};
        2'd2:    rdata_d = 32'(high_q);
        2'd3:    rdata_d = 32'(period_q);
        default: rdata_d = 32'd0;
      endcase
    end else begin
      rdata_d = rdata_q;
    end

    if (wr_s && wstrb_i[0]) begin
      case (addr_i[3:2])
        2'd0: enable_d = wdata_i[0];
        2'd1: begin
          new_d = new_q & ~wdata_i[0];
          ovf_d = ovf_q & ~wdata_i[1];
        end
        default: begin
          enable_d = enable_q;
        end
      endcase
    end else begin
      enable_d = enable_q;
    end

    // Status sets come after the W1C so a capture in the same cycle wins
    if (!enable_q) begin
      high_cnt_d   = '0;
      period_cnt_d = '0;
      armed_d      = 1'b0;
    end else if (rise_s) begin
      if (armed_q) begin
        period_d = sat_inc(period_cnt_q);
        high_d   = high_cnt_q;
        new_d    = 1'b1;
      end else begin
        period_d = period_q;
      end
      period_cnt_d = '0;
      high_cnt_d   = CNT_ONE;
      armed_d      = 1'b1;
    end else if (period_cnt_q == CNT_MAX) begin
      period_cnt_d = period_cnt_q;
    end else begin
      period_cnt_d = period_cnt_q + CNT_ONE;
      if (s_s) begin
        high_cnt_d = sat_inc(high_cnt_q);
      end else begin
        high_cnt_d = high_cnt_q;
      end
      if (period_cnt_q + CNT_ONE == CNT_MAX) begin
        ovf_d   = 1'b1;
        armed_d = 1'b0;
      end else begin
        armed_d = armed_q;
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q       <= '0;
      prev_q       <= 1'b0;
      enable_q     <= 1'b0;
      armed_q      <= 1'b0;
      new_q        <= 1'b0;
      ovf_q        <= 1'b0;
      high_q       <= '0;
      period_q     <= '0;
      high_cnt_q   <= '0;
      period_cnt_q <= '0;
      ready_q      <= 1'b0;
      rdata_q      <= 32'd0;
    end else begin
      sync_q       <= sync_d;
      prev_q       <= prev_d;
      enable_q     <= enable_d;
      armed_q      <= armed_d;
      new_q        <= new_d;
      ovf_q        <= ovf_d;
      high_q       <= high_d;
      period_q     <= period_d;
      high_cnt_q   <= high_cnt_d;
      period_cnt_q <= period_cnt_d;
      ready_q      <= ready_d;
      rdata_q      <= rdata_d;
    end
  end
endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: timestamp-based reference model checked every
// cycle, directed scenarios with literal expectations, and randomized PWM/bus traffic.
module tb_pwm_capture;
  localparam int W    = 8;
  localparam int S    = 2;
  localparam int MAXV = 255;
  localparam int HN   = 16384;

  logic        clk = 1'b0;
  logic        reset, valid, ready, in_s;
  logic [3:0]  wstrb;
  logic [31:0] addr, wdata, rdata;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pwm_capture #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk_i(clk), .reset_i(reset), .valid_i(valid), .ready_o(ready),
    .wstrb_i(wstrb), .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata), .in_i(in_s)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // PWM source: 0 const low, 1 const high, 2 periodic, 3 manual
  int   pwm_mode = 0, pwm_period = 100, pwm_high = 25, ph = 0;
  bit   pwm_restart = 1'b0;
  logic manual_in = 1'b0;
  initial begin
    in_s = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (pwm_restart) begin ph = 0; pwm_restart = 1'b0; end
      case (pwm_mode)
        0: in_s = 1'b0;
        1: in_s = 1'b1;
        2: begin
          in_s = (ph < pwm_high);
          ph++;
          if (ph >= pwm_period) ph = 0;
        end
        default: in_s = manual_in;
      endcase
    end
  end

  // Reference model: measurement from edge timestamps and sample history
  bit          m_live = 1'b0;
  logic        m_ready, m_en, m_new, m_ovf, m_prev;
  logic [31:0] m_rdata;
  int          m_high, m_period, m_b, m_e0, t = 0;
  bit          m_armed;
  logic        dly [S];
  bit          hist [HN];

  function automatic logic [31:0] m_reg(input logic [1:0] sel);
    case (sel)
      2'd0:    return {31'd0, m_en};
      2'd1:    return {30'd0, m_ovf, m_new};
      2'd2:    return 32'(m_high);
      default: return 32'(m_period);
    endcase
  endfunction

  always @(negedge clk) begin
    logic s, rise, acc, n_en, n_new, n_ovf;
    int hsum;
    if (m_live) begin
      check("ready", {31'd0, ready}, {31'd0, m_ready});
      check("rdata", rdata, m_rdata);
    end
    s = dly[S-1];
    rise = s & ~m_prev;
    if (t < HN) hist[t] = s;
    if (reset === 1'b1) begin
      m_live = 1'b1; m_ready = 1'b0; m_rdata = 32'd0;
      m_en = 1'b0; m_new = 1'b0; m_ovf = 1'b0; m_high = 0; m_period = 0;
      m_armed = 1'b0; m_b = t + 1; m_e0 = t; m_prev = 1'b0;
      for (int i = 0; i < S; i++) dly[i] = 1'b0;
    end else if (m_live) begin
      acc = valid && !m_ready;
      n_en = m_en; n_new = m_new; n_ovf = m_ovf;
      if (acc) m_rdata = m_reg(addr[3:2]);
      if (acc && wstrb != 4'h0 && wstrb[0]) begin
        if (addr[3:2] == 2'd0) n_en = wdata[0];
        if (addr[3:2] == 2'd1) begin
          n_new = m_new & ~wdata[0];
          n_ovf = m_ovf & ~wdata[1];
        end
      end
      if (!m_en) begin
        m_armed = 1'b0; m_b = t + 1;
      end else if (rise) begin
        if (m_armed) begin
          hsum = 0;
          for (int k = m_e0; k < t && k < HN; k++) hsum += int'(hist[k]);
          m_period = (t - m_e0 > MAXV) ? MAXV : t - m_e0;
          m_high = (hsum > MAXV) ? MAXV : hsum;
          n_new = 1'b1;
        end
        m_armed = 1'b1; m_e0 = t; m_b = t + 1;
      end else if (t - m_b == MAXV - 1) begin
        n_ovf = 1'b1; m_armed = 1'b0;
      end
      m_ready = acc;
      m_en = n_en; m_new = n_new; m_ovf = n_ovf;
      for (int i = S - 1; i > 0; i--) dly[i] = dly[i-1];
      dly[0] = in_s;
      m_prev = s;
    end
    t++;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic access(input logic [31:0] a, input logic [3:0] st, input logic [31:0] d,
                        output logic [31:0] rd, output logic r1, output logic r0);
    valid = 1'b1; addr = a; wstrb = st; wdata = d;
    tick();
    rd = rdata; r1 = ready;
    valid = 1'b0; wstrb = 4'h0;
    tick();
    r0 = ready;
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] st, input logic [31:0] d);
    logic [31:0] rd; logic r1, r0;
    access(a, st, d, rd, r1, r0);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rd; logic r1, r0;
    access(a, 4'h0, 32'd0, rd, r1, r0);
    check(name, rd, exp);
  endtask

  int rel0 = 0;
  task automatic wait_rel(input int n);
    while (cyc < rel0 + n) tick();
  endtask

  task automatic pwm_start(input int p, input int h);
    pwm_period = p; pwm_high = h; pwm_restart = 1'b1; pwm_mode = 2; rel0 = cyc;
  endtask

  initial begin
    logic [31:0] rd; logic r1, r0;
    reset = 1'b1; valid = 1'b0; wstrb = 4'h0; addr = 32'd0; wdata = 32'd0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset values and single-cycle ready pulse
    for (int a = 0; a < 4; a++) begin
      access(32'(a * 4), 4'h0, 32'd0, rd, r1, r0);
      check("reset_read", rd, 32'd0);
      check("ready_pulse_hi", {31'd0, r1}, 32'd1);
      check("ready_pulse_lo", {31'd0, r0}, 32'd0);
    end

    // Period 100 / high 25
    wr(32'h0, 4'hF, 32'd1);
    pwm_start(100, 25);
    wait_rel(450);
    pwm_mode = 0;
    rd_chk("high_25", 32'h8, 32'd25);
    rd_chk("period_100", 32'hC, 32'd100);
    rd_chk("status_new", 32'h4, 32'd1);
    wr(32'h4, 4'h1, 32'd1);
    rd_chk("status_cleared", 32'h4, 32'd0);

    // Constant low saturates, then re-arm without capture
    repeat (300) tick();
    rd_chk("status_ovf", 32'h4, 32'd2);
    rd_chk("high_kept", 32'h8, 32'd25);
    rd_chk("period_kept", 32'hC, 32'd100);
    wr(32'h4, 4'h1, 32'd3);
    pwm_start(50, 10);
    wait_rel(80);
    pwm_mode = 0;
    rd_chk("period_50", 32'hC, 32'd50);
    rd_chk("high_10", 32'h8, 32'd10);
    rd_chk("status_after_rearm", 32'h4, 32'd1);

    // W1C in the capture cycle: the set wins
    wr(32'h4, 4'h1, 32'd1);
    rd_chk("status_pre_race", 32'h4, 32'd0);
    manual_in = 1'b0; pwm_mode = 3;
    repeat (3) tick();
    manual_in = 1'b1;
    tick(); tick();
    wr(32'h4, 4'h1, 32'd1);
    rd_chk("status_set_wins", 32'h4, 32'd1);
    manual_in = 1'b0;
    repeat (5) tick();

    // Disable mid-period discards; first edge after re-enable only arms
    pwm_start(60, 20);
    wait_rel(140);
    wr(32'h0, 4'hF, 32'd0);
    wr(32'h4, 4'h1, 32'd3);
    wait_rel(150);
    wr(32'h0, 4'hF, 32'd1);
    wait_rel(200);
    rd_chk("status_no_capture", 32'h4, 32'd0);
    rd_chk("period_old", 32'hC, 32'd60);
    wait_rel(260);
    rd_chk("status_recapture", 32'h4, 32'd1);
    rd_chk("period_60", 32'hC, 32'd60);
    rd_chk("high_20", 32'h8, 32'd20);
    wr(32'h8, 4'hF, 32'hFFFF_FFFF);
    rd_chk("high_ro", 32'h8, 32'd20);
    valid = 1'b0; wstrb = 4'hF; addr = 32'h0; wdata = 32'd0;
    repeat (5) tick();
    wstrb = 4'h0;
    rd_chk("ctrl_idle_strobe", 32'h0, 32'd1);

    // Randomized PWM and bus traffic, checked by the model each cycle
    for (int r = 0; r < 6; r++) begin
      pwm_start(int'($urandom_range(20, 120)), 1);
      pwm_high = int'($urandom_range(1, 19));
      if (r == 4) pwm_mode = 1;
      repeat (300) begin
        valid = ($urandom_range(0, 3) == 0);
        addr  = $urandom;
        wstrb = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        wdata = $urandom;
        if (addr[3:2] == 2'd0) wdata[0] = ($urandom_range(0, 7) != 0);
        tick();
      end
      valid = 1'b0; wstrb = 4'h0;
      tick(); tick();
    end
    pwm_mode = 0;

    // Reset during a held valid
    wr(32'h0, 4'hF, 32'd1);
    valid = 1'b1; addr = 32'h8; wstrb = 4'h0;
    tick();
    check("held_ready_hi", {31'd0, ready}, 32'd1);
    reset = 1'b1;
    tick();
    check("reset_ready", {31'd0, ready}, 32'd0);
    check("reset_rdata", rdata, 32'd0);
    reset = 1'b0; valid = 1'b0;
    tick();
    for (int a = 0; a < 4; a++) rd_chk("post_reset_read", 32'(a * 4), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
